truth_table_checker: RTL and testbench

//  Exhaustive, clocked verifier for N-input combinational functions.

---
 rtl/truth_table_checker_pkg.sv | 22 ++
 rtl/tt_sweep_counter.sv | 39 +++
 rtl/truth_table_checker.sv | 114 +++++++++++
 tb/tb_truth_table_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types for the truth table checker.
// FSM encoding and the reference-bit selector.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE_W = 2'd1,
        SAMPLE   = 2'd2,
        DONE     = 2'd3
    } tt_state_e;

    localparam int SETTLE_BITS = 4;

    function automatic logic ref_bit(
        input logic mode,
        input logic golden_bit,
        input logic y_b
    );
        return mode ? golden_bit : y_b;
    endfunction

endpackage

// File: rtl/tt_sweep_counter.sv
// Settle-delay counter and stimulus vector counter.
// stim wraps to 0 when stepped past all-ones, which ends the sweep.
module tt_sweep_counter
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            settle,
    input  logic            step,
    output logic [N_IN-1:0] stim,
    output logic            sample_en,
    output logic            last_vec
);

    localparam logic [SETTLE_BITS-1:0] SETTLE_LAST =
        (SETTLE == 0) ? '0 : SETTLE_BITS'(SETTLE - 1);

    logic [SETTLE_BITS-1:0] settle_cnt;

    assign sample_en = (settle_cnt == SETTLE_LAST);
    assign last_vec  = &stim;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            stim       <= '0;
            settle_cnt <= '0;
        end else begin
            if (settle)
                settle_cnt <= sample_en ? '0 : settle_cnt + 1'b1;
            if (step)
                stim <= stim + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive clocked equivalence / golden-table checker
// for N_IN-input combinational functions.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [(1<<N_IN)-1:0] golden,
    output logic [N_IN-1:0]      stim,
    input  logic                 y_a,
    input  logic                 y_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        ones_a,
    output logic [N_IN:0]        mismatches,
    output logic [N_IN-1:0]      first_bad
);

    localparam int NV = 1 << N_IN;
    localparam tt_state_e RUN = (SETTLE == 0) ? SAMPLE : SETTLE_W;

    tt_state_e     state;
    logic          mode_q;
    logic [NV-1:0] golden_q;
    logic          load;
    logic          settle;
    logic          step;
    logic          sample_en;
    logic          last_vec;
    logic          miss;
    logic [N_IN:0] ones_nx;
    logic [N_IN:0] mism_nx;

    assign load    = (state == IDLE) && start;
    assign settle  = (state == SETTLE_W);
    assign step    = (state == SAMPLE);
    assign miss    = y_a != ref_bit(mode_q, golden_q[stim], y_b);
    assign ones_nx = ones_a + {{N_IN{1'b0}}, y_a};
    assign mism_nx = mismatches + {{N_IN{1'b0}}, miss};

    tt_sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_sweep (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .settle    (settle),
        .step      (step),
        .stim      (stim),
        .sample_en (sample_en),
        .last_vec  (last_vec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            golden_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            ones_a     <= '0;
            mismatches <= '0;
            first_bad  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        mode_q     <= mode;
                        golden_q   <= golden;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        ones_a     <= '0;
                        mismatches <= '0;
                        first_bad  <= '0;
                    end
                end
                SETTLE_W: begin
                    if (sample_en)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    ones_a     <= ones_nx;
                    mismatches <= mism_nx;
                    // only the lowest failing vector is kept
                    if (miss && mismatches == '0)
                        first_bad <= stim;
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mism_nx == '0);
                    end else begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: N_IN=3/SETTLE=1 and
// N_IN=4/SETTLE=0 instances, table-driven sweeps plus corner sequences.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start3, start4;
    logic        mode;
    logic [7:0]  golden3;
    logic [15:0] golden4;
    logic [2:0]  stim3;
    logic [3:0]  stim4;
    logic        y_a3, y_b3, y_a4, y_b4;
    logic        busy3, done3, pass3, busy4, done4, pass4;
    logic [3:0]  ones3, mism3;
    logic [4:0]  ones4, mism4;
    logic [2:0]  first3;
    logic [3:0]  first4;

    int sa = 3;
    int sb = 3;
    bit cur = 1'b0;

    truth_table_checker #(.N_IN(3), .SETTLE(1)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .mode(mode),
        .golden(golden3), .stim(stim3), .y_a(y_a3), .y_b(y_b3),
        .busy(busy3), .done(done3), .pass(pass3), .ones_a(ones3),
        .mismatches(mism3), .first_bad(first3)
    );

    truth_table_checker #(.N_IN(4), .SETTLE(0)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode),
        .golden(golden4), .stim(stim4), .y_a(y_a4), .y_b(y_b4),
        .busy(busy4), .done(done4), .pass(pass4), .ones_a(ones4),
        .mismatches(mism4), .first_bad(first4)
    );

    function automatic logic fn(input int sel, input logic [3:0] s, input bit w4);
        logic a, b, c;
        a = w4 ? s[3] : s[2];
        b = w4 ? s[2] : s[1];
        c = w4 ? s[1] : s[0];
        case (sel)
            0: return (a & ~b) | (a & c);
            1: return a & ~b;
            2: return 1'b1;
            3: return 1'b0;
            4: return a ^ b ^ c;
            default: return w4 ? &s : &s[2:0];
        endcase
    endfunction

    always_comb begin
        y_a3 = fn(sa, {1'b0, stim3}, 1'b0);
        y_b3 = fn(sb, {1'b0, stim3}, 1'b0);
        y_a4 = fn(sa, stim4, 1'b1);
        y_b4 = fn(sb, stim4, 1'b1);
    end

    int c_busy, c_done, c_pass, c_ones, c_mism, c_first, c_stim;
    always_comb begin
        c_busy  = cur ? int'(busy4)  : int'(busy3);
        c_done  = cur ? int'(done4)  : int'(done3);
        c_pass  = cur ? int'(pass4)  : int'(pass3);
        c_ones  = cur ? int'(ones4)  : int'(ones3);
        c_mism  = cur ? int'(mism4)  : int'(mism3);
        c_first = cur ? int'(first4) : int'(first3);
        c_stim  = cur ? int'(stim4)  : int'(stim3);
    end

    typedef struct {
        bit          use4;
        bit          mode;
        logic [15:0] golden;
        int          sa;
        int          sb;
        int          ones;
        int          mism;
        int          first;
        int          pass;
        int          lat;
    } vec_t;

    typedef struct {
        int ones;
        int mism;
        int first;
        int pass;
        int lat;
    } exp_t;

    exp_t  sbq[$];
    vec_t  tv[8];
    int    checks = 0;
    int    errors = 0;
    string tag = "reset";

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit u4, input bit md, input logic [15:0] g,
                                input int a, input int b, input int on,
                                input int mm, input int fb, input int ps);
        vec_t v;
        v.use4 = u4; v.mode = md; v.golden = g; v.sa = a; v.sb = b;
        v.ones = on; v.mism = mm; v.first = fb; v.pass = ps;
        v.lat  = 16;
        return v;
    endfunction

    task automatic set_start(input bit u4, input logic val);
        if (u4) start4 = val;
        else    start3 = val;
    endtask

    task automatic drive(input vec_t v);
        cur     = v.use4;
        mode    = v.mode;
        golden3 = v.golden[7:0];
        golden4 = v.golden;
        sa      = v.sa;
        sb      = v.sb;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.ones = v.ones; e.mism = v.mism; e.first = v.first;
        e.pass = v.pass; e.lat = v.lat;
        sbq.push_back(e);
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_done(input int poke_at, input bit hold);
        int   cyc = 0;
        int   stim_bad = 0;
        int   s;
        exp_t e;
        while (c_done !== 1 && cyc < 200) begin
            s = cur ? cyc : cyc / 2;
            if (c_stim !== s) stim_bad++;
            if (cyc == poke_at)
                set_start(cur, 1'b1);
            else if (!hold)
                set_start(cur, 1'b0);
            @(negedge clk);
            cyc++;
        end
        if (c_done !== 1) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: no done after %0d cycles", tag, cyc);
            if (sbq.size() > 0) void'(sbq.pop_front());
            return;
        end
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s/scoreboard: done with no expected entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk("latency",   cyc,     e.lat);
        chk("stim_seq",  stim_bad, 0);
        chk("ones_a",    c_ones,  e.ones);
        chk("mismatch",  c_mism,  e.mism);
        chk("first_bad", c_first, e.first);
        chk("pass",      c_pass,  e.pass);
        chk("busy_done", c_busy,  0);
        chk("stim_done", c_stim,  0);
    endtask

    task automatic sweep(input vec_t v, input int poke_at, input bit hold);
        drive(v);
        push_exp(v);
        @(negedge clk);
        set_start(v.use4, 1'b1);
        @(negedge clk);
        chk("busy_start", c_busy, 1);
        wait_done(poke_at, hold);
    endtask

    initial begin
        int pulses;
        reset   = 1'b1;
        start3  = 1'b0;
        start4  = 1'b0;
        mode    = 1'b0;
        golden3 = 8'hFF;
        golden4 = 16'hFFFF;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            cur = bit'(u);
            #1;
            chk("rst_busy",  c_busy,  0);
            chk("rst_done",  c_done,  0);
            chk("rst_pass",  c_pass,  0);
            chk("rst_ones",  c_ones,  0);
            chk("rst_mism",  c_mism,  0);
            chk("rst_first", c_first, 0);
            chk("rst_stim",  c_stim,  0);
        end
        reset = 1'b0;

        tv[0] = mk(0, 1, 16'h00B0, 0, 3, 3, 0, 0, 1);
        tv[1] = mk(0, 0, 16'h0000, 0, 1, 3, 1, 7, 0);
        tv[2] = mk(0, 1, 16'h0096, 4, 0, 4, 0, 0, 1);
        tv[3] = mk(0, 0, 16'h0000, 4, 3, 4, 4, 1, 0);
        tv[4] = mk(0, 1, 16'h0000, 2, 0, 8, 8, 0, 0);
        tv[5] = mk(1, 0, 16'h0000, 2, 2, 16, 0, 0, 1);
        tv[6] = mk(1, 1, 16'h8000, 5, 3, 1, 0, 0, 1);
        tv[7] = mk(1, 1, 16'h0400, 5, 3, 1, 2, 10, 0);

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            sweep(tv[i], -1, 1'b0);
        end

        tag = "restart_ignored";
        sweep(tv[0], 5, 1'b0);

        tag = "mid_reset";
        drive(tv[4]);
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("busy",  busy3,  0);
        chk("done",  done3,  0);
        chk("stim",  stim3,  0);
        chk("ones",  ones3,  0);
        chk("mism",  mism3,  0);
        chk("first", first3, 0);
        chk("pass",  pass3,  0);
        reset  = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done3 === 1'b1) pulses++;
        end
        chk("no_done", pulses, 0);

        tag = "start_held";
        sweep(tv[4], -1, 1'b1);
        @(negedge clk);
        chk("idle_busy", busy3, 0);
        chk("idle_done", done3, 0);
        @(negedge clk);
        chk("rearm_busy", busy3, 1);
        chk("rearm_ones", ones3, 0);
        push_exp(tv[4]);
        wait_done(-1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
